// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter sharing one RIB slave port between core data (m0),
// core fetch (m1) and JTAG debug (m2), with a no-ack watchdog.
module rib_rr_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_data_i,
  output logic [DATA_W-1:0] m2_data_o,
  output logic              m2_ack_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [2:0]        grant_o,
  output logic              hold_flag_o,
  output logic              err_o,
  output logic              state_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  grant;
  logic [1:0]  ptr;
  logic [7:0]  cnt;

  logic [2:0]        req_v;
  logic [2:0]        pick;
  logic              busy;
  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [1:0]        next_ptr;
  logic              fire_to;
  logic              done;
  logic [DATA_W-1:0] rdata;

  assign req_v = {m2_req_i, m1_req_i, m0_req_i};
  assign busy  = (state == BUSY);
  assign g_req = |(grant & req_v);

  // First requester scanning upward from the pointer, wrapping mod 3.
  always_comb begin
    pick = 3'b000;
    for (int i = 0; i < 3; i++) begin
      int idx;
      idx = (int'(ptr) + i) % 3;
      if (pick == 3'b000 && req_v[idx]) pick = 3'b001 << idx;
    end
  end

  always_comb begin
    g_we     = 1'b0;
    g_addr   = '0;
    g_data   = '0;
    next_ptr = 2'd0;
    unique case (grant)
      3'b001: begin g_we = m0_we_i; g_addr = m0_addr_i; g_data = m0_data_i; next_ptr = 2'd1; end
      3'b010: begin g_we = m1_we_i; g_addr = m1_addr_i; g_data = m1_data_i; next_ptr = 2'd2; end
      3'b100: begin g_we = m2_we_i; g_addr = m2_addr_i; g_data = m2_data_i; next_ptr = 2'd0; end
      default: ;
    endcase
  end

  // A slave ack in the watchdog's last cycle wins over the abort.
  assign fire_to = busy & g_req & ~s_ack_i & (cnt == TO_LAST);
  assign done    = busy & g_req & (s_ack_i | fire_to);
  assign rdata   = (busy & s_ack_i) ? s_data_i : '0;

  assign s_req_o  = busy & g_req & ~fire_to;
  assign s_we_o   = busy & g_we;
  assign s_addr_o = busy ? g_addr : '0;
  assign s_data_o = busy ? g_data : '0;

  assign m0_ack_o  = done & grant[0];
  assign m1_ack_o  = done & grant[1];
  assign m2_ack_o  = done & grant[2];
  assign m0_data_o = (done & grant[0]) ? rdata : '0;
  assign m1_data_o = (done & grant[1]) ? rdata : '0;
  assign m2_data_o = (done & grant[2]) ? rdata : '0;

  assign err_o       = fire_to;
  assign grant_o     = grant;
  assign state_o     = state;
  assign hold_flag_o = rst & ((m0_req_i & ~(busy & grant[0])) |
                              (m1_req_i & ~(busy & grant[1])));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= 3'b000;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_v) begin
            state <= BUSY;
            grant <= pick;
            cnt   <= 8'd0;
          end
        end
        BUSY: begin
          // Ack, silent drop by the grantee, or watchdog all end the transaction.
          if (s_ack_i | ~g_req | fire_to) begin
            state <= IDLE;
            grant <= 3'b000;
            ptr   <= next_ptr;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
